// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_t          receiver FSM states
//   UART_DATA_BITS      data bits per frame (8N1)
//   UART_RX_FIFO_DEPTH  receive buffer depth when UART_RX_FIFO_EN is defined
//   clamp_cpb()         applies the lower clamp to the software bit divisor
package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_RX_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic [15:0] clamp_cpb(input logic [15:0] cpb,
                                            input logic [15:0] min_cpb);
    return (cpb < min_cpb) ? min_cpb : cpb;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received bytes.
// Only instantiated when UART_RX_FIFO_EN is defined.
//   clk, rst  clock, synchronous active-high reset
//   push_i    write data_i (ignored when full unless a pop happens in the same cycle)
//   data_i    byte to write
//   pop_i     drop the head entry (ignored when empty)
//   data_o    head entry
//   full_o    all entries occupied
//   empty_o   no entries occupied
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] data_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(UART_RX_FIFO_DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [UART_RX_FIFO_DEPTH];
  logic [AW-1:0]             rd_ptr_q, wr_ptr_q;
  logic [AW:0]               count_q;
  logic                      do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(UART_RX_FIFO_DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO can accept
  // a push alongside a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset as well because data_o is the raw head
      // entry and must read 0x00 after reset; at four bytes this is cheap.
      for (int i = 0; i < UART_RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding the UART register file.
// Build option: UART_RX_FIFO_EN selects a 4-entry receive FIFO; otherwise a
// single holding register buffers the received byte.
//   clk, rst      clock, synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   clks_per_bit  software bit divisor, clamped to MIN_CLKS_PER_BIT, latched at start edge
//   rx_data       byte at the head of the buffer (valid while read_ready)
//   read_ready    buffer holds at least one byte
//   read_ack      one-cycle pulse popping the head byte
//   frame_error   sticky: stop bit sampled low
//   overrun       sticky: byte arrived while the buffer was full
//   err_clear     clears both sticky flags (a simultaneous set wins)
//   busy          a frame is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int MIN_CLKS_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic [15:0]               clks_per_bit,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      read_ready,
  input  logic                      read_ack,
  output logic                      frame_error,
  output logic                      overrun,
  input  logic                      err_clear,
  output logic                      busy
);

  localparam int          IDXW     = $clog2(UART_DATA_BITS);
  localparam logic [15:0] MIN_CPB  = 16'(MIN_CLKS_PER_BIT);
  localparam logic [IDXW-1:0] LAST_BIT = IDXW'(UART_DATA_BITS - 1);

  // Two-flop synchroniser; both flops reset to the idle level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value; here rx_s_q gets the old rx_meta_q.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_t                 state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [15:0]               cpb_q, cpb_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      half_bit, bit_end;
  logic                      deliver, frame_err_set;

  assign half_bit = (cnt_q == (cpb_q >> 1));
  assign bit_end  = (cnt_q == (cpb_q - 16'd1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cpb_q   <= MIN_CPB;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next state and datapath update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    cpb_d   = cpb_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
          cpb_d   = clamp_cpb(clks_per_bit, MIN_CPB);
        end
      end
      START: begin
        if (half_bit) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting right leaves bit [index] in place
          // once all bits are in.
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IDXW'(1);
          if (idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy          = (state_q != IDLE);
    deliver       = 1'b0;
    frame_err_set = 1'b0;
    if (state_q == STOP && bit_end) begin
      deliver       = rx_s_q;
      frame_err_set = !rx_s_q;
    end
  end

  // Receive buffer. A pop in the delivery cycle frees space first.
  logic pop, full, push_ok, overrun_set;

  assign pop         = read_ack && read_ready;
  assign push_ok     = deliver && (!full || pop);
  assign overrun_set = deliver && full && !pop;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  uart_rx_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_data),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  assign read_ready = !fifo_empty;
`else
  logic [UART_DATA_BITS-1:0] hold_q;
  logic                      valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push_ok) begin
      hold_q  <= shift_q;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign full       = valid_q;
  assign read_ready = valid_q;
  assign rx_data    = hold_q;
`endif

  // Sticky status flags; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_err_set)  frame_error <= 1'b1;
      else if (err_clear) frame_error <= 1'b0;
      if (overrun_set)    overrun     <= 1'b1;
      else if (err_clear) overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Works with or without
// UART_RX_FIFO_EN (buffer depth 4 or 1).
module tb_uart_rx;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] clks_per_bit;
  logic [7:0]  rx_data;
  logic        read_ready;
  logic        read_ack;
  logic        frame_error;
  logic        overrun;
  logic        err_clear;
  logic        busy;

  int total = 0;
  int bad   = 0;

  uart_rx #(.MIN_CLKS_PER_BIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .clks_per_bit (clks_per_bit),
    .rx_data      (rx_data),
    .read_ready   (read_ready),
    .read_ack     (read_ack),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .err_clear    (err_clear),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Drive one frame on the pin, bt cycles per bit. ack_tick (>0) raises
  // read_ack for the single cycle following that many ticks; scramble changes
  // clks_per_bit once the divisor has been latched. rx is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input int bt, input bit stop_ok,
                            input int ack_tick, input bit scramble);
    logic [9:0] bits;
    int t;
    bits = {stop_ok, b, 1'b0};
    t = 0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (bt) begin
        tick();
        t++;
        read_ack = (t == ack_tick);
        if (scramble && t == 3) clks_per_bit = 16'($urandom_range(0, 65535));
      end
    end
    read_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic read_byte(input string nm, input logic [7:0] exp);
    check({nm, "_ready"}, 32'(read_ready), 32'd1);
    check({nm, "_data"}, 32'(rx_data), 32'(exp));
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  typedef struct {
    logic [15:0] cpb_in;
    int          bit_time;
    logic [7:0]  data;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the random phase.
  logic [7:0] mq[$];
  bit m_ov, m_fe;

  initial begin
    logic [7:0] b, junk;
    logic [15:0] cin;
    int bt;
    bit good;

    rst = 1'b1; rx = 1'b1; clks_per_bit = 16'd16;
    read_ack = 1'b0; err_clear = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy", 32'(busy), 0);
    check("reset_ready", 32'(read_ready), 0);
    check("reset_data", 32'(rx_data), 0);
    check("reset_fe", 32'(frame_error), 0);
    check("reset_ov", 32'(overrun), 0);

    // Single frames: cpb below the clamp must act as 4 cycles per bit.
    vecs[0] = '{16'd16, 16, 8'h55, 8'h55};
    vecs[1] = '{16'd1,  4,  8'hF0, 8'hF0};
    vecs[2] = '{16'd0,  4,  8'h3C, 8'h3C};
    vecs[3] = '{16'd7,  7,  8'hA5, 8'hA5};
    vecs[4] = '{16'd8,  8,  8'h00, 8'h00};
    vecs[5] = '{16'd5,  5,  8'hFF, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      clks_per_bit = vecs[i].cpb_in;
      send_frame(vecs[i].data, vecs[i].bit_time, 1'b1, 0, 1'b0);
      idle(6);
      check($sformatf("vec%0d_fe", i), 32'(frame_error), 0);
      check($sformatf("vec%0d_ov", i), 32'(overrun), 0);
      read_byte($sformatf("vec%0d", i), vecs[i].exp_data);
      check($sformatf("vec%0d_after_ack", i), 32'(read_ready), 0);
    end

    // Glitch rejection.
    clks_per_bit = 16'd16;
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    check("glitch_busy_mid", 32'(busy), 1);
    repeat (10) tick();
    check("glitch_busy_end", 32'(busy), 0);
    check("glitch_ready", 32'(read_ready), 0);
    check("glitch_fe", 32'(frame_error), 0);

    // Framing error, break, then recovery.
    send_frame(8'hA3, 16, 1'b0, 0, 1'b0);
    repeat (48) tick();
    check("frame_fe", 32'(frame_error), 1);
    check("frame_ready", 32'(read_ready), 0);
    check("frame_break_busy", 32'(busy), 1);
    rx = 1'b1;
    repeat (4) tick();
    check("frame_break_exit", 32'(busy), 0);
    pulse_clear();
    check("frame_fe_cleared", 32'(frame_error), 0);
    send_frame(8'h3C, 16, 1'b1, 0, 1'b0);
    idle(6);
    read_byte("after_break", 8'h3C);

    // Overrun: one more frame than the buffer holds, back to back.
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'((i + 1) * 17);
      send_frame(b, 16, 1'b1, 0, 1'b0);
    end
    idle(6);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_head", 32'(rx_data), 32'h11);
    pulse_clear();
    check("ovr_cleared", 32'(overrun), 0);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'((i + 1) * 17);
      read_byte("ovr_drain", b);
    end
    check("ovr_empty", 32'(read_ready), 0);

    // read_ack in the delivery cycle: sync (2) + detect (1) + half bit + 9 bits.
    send_frame(8'h11, 16, 1'b1, 0, 1'b0);
    idle(6);
    send_frame(8'h22, 16, 1'b1, 3 + 8 + 9 * 16, 1'b0);
    idle(6);
    check("simul_data", 32'(rx_data), 32'h22);
    check("simul_ready", 32'(read_ready), 1);
    check("simul_ov", 32'(overrun), 0);
    read_byte("simul_drain", 8'h22);
    check("simul_empty", 32'(read_ready), 0);

    // Reset in the middle of DATA with a byte buffered.
    clks_per_bit = 16'd1;
    send_frame(8'hF0, 4, 1'b1, 0, 1'b0);
    idle(6);
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (8) tick();
    check("rst_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(read_ready), 0);
    check("rst_data", 32'(rx_data), 0);
    rst = 1'b0;
    idle(4);
    check("rst_idle_busy", 32'(busy), 0);

    // Random frames against the queue model.
    m_ov = 1'b0; m_fe = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cin  = 16'($urandom_range(0, 10));
      bt   = (cin < 4) ? 4 : int'(cin);
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      clks_per_bit = cin;
      send_frame(b, bt, good, 0, 1'b1);
      if (good) begin
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ov = 1'b1;
      end else begin
        m_fe = 1'b1;
        repeat (2 * bt) tick();
      end
      idle(6);
      check("rnd_ready", 32'(read_ready), 32'(mq.size() != 0));
      if (mq.size() != 0) check("rnd_head", 32'(rx_data), 32'(mq[0]));
      check("rnd_ov", 32'(overrun), 32'(m_ov));
      check("rnd_fe", 32'(frame_error), 32'(m_fe));
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        if (mq.size() != 0) begin
          read_byte("rnd_read", mq[0]);
          junk = mq.pop_front();
        end else begin
          read_ack = 1'b1;
          tick();
          read_ack = 1'b0;
          check("rnd_empty_ack", 32'(read_ready), 0);
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        pulse_clear();
        m_ov = 1'b0;
        m_fe = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
